// File: rtl/pc_seq_ctrl.sv
// Fetch sequencer: reads the PC, fetches the instruction, hands it to decode and writes back the next PC.
// Optional fetch watchdog enabled by defining PCSEQ_FETCH_TIMEOUT_EN.
module pc_seq_ctrl #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic          re_pc,
  output logic          wr_pc,
  output logic [17:0]   pc_in,
  input  logic [17:0]   pc_out,
  input  logic          redirect_valid,
  input  logic [17:0]   redirect_addr,
  output logic          imem_req,
  output logic [17:0]   imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr,
  output logic [17:0]   instr_pc,
  output logic          busy,
  output logic          fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RDPC  = 3'd1,
    S_LATCH = 3'd2,
    S_FETCH = 3'd3,
    S_ISSUE = 3'd4
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t         state_reg;
  logic [17:0]    cur_pc_reg;
  logic           pend_reg;
  logic [17:0]    pend_addr_reg;
  logic           re_pc_reg;
  logic           imem_req_reg;
  logic           instr_valid_reg;
  logic [DW-1:0]  instr_reg;
  logic [17:0]    instr_pc_reg;
  logic           err_block;
  logic           handshake;
  logic [17:0]    next_pc;

  // The PC write has to land in the handshake cycle itself so the
  // following RDPC reads the updated register; hence it is combinational.
  assign handshake = (state_reg == S_ISSUE) && instr_ready;

  always_comb begin
    next_pc = cur_pc_reg + 18'd1;
    if (redirect_valid) begin
      next_pc = redirect_addr;
    end else if (pend_reg) begin
      next_pc = pend_addr_reg;
    end
  end

`ifdef PCSEQ_FETCH_TIMEOUT_EN
  logic [7:0] to_cnt_reg;
  logic       fetch_err_reg;

  assign err_block = fetch_err_reg;
  assign fetch_err = fetch_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_reg    <= 8'd0;
      fetch_err_reg <= 1'b0;
    end else begin
      if (state_reg == S_LATCH) begin
        to_cnt_reg <= 8'd0;
      end else if (state_reg == S_FETCH && !imem_ack) begin
        if (to_cnt_reg == TO_LAST) begin
          fetch_err_reg <= 1'b1;
        end else begin
          to_cnt_reg <= to_cnt_reg + 8'd1;
        end
      end
    end
  end

  logic fetch_timeout;
  assign fetch_timeout = (state_reg == S_FETCH) && !imem_ack && (to_cnt_reg == TO_LAST);
`else
  logic fetch_timeout;
  logic unused_timeout_cfg;

  assign fetch_timeout      = 1'b0;
  assign err_block          = 1'b0;
  assign fetch_err          = 1'b0;
  assign unused_timeout_cfg = ^TO_LAST;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      cur_pc_reg      <= 18'd0;
      pend_reg        <= 1'b0;
      pend_addr_reg   <= 18'd0;
      re_pc_reg       <= 1'b0;
      imem_req_reg    <= 1'b0;
      instr_valid_reg <= 1'b0;
      instr_reg       <= '0;
      instr_pc_reg    <= 18'd0;
    end else begin
      // A redirect seen in the handshake cycle is consumed directly via next_pc.
      if (handshake) begin
        pend_reg <= 1'b0;
      end else if (redirect_valid) begin
        pend_reg      <= 1'b1;
        pend_addr_reg <= redirect_addr;
      end

      case (state_reg)
        S_IDLE: begin
          if (run && !err_block) begin
            state_reg <= S_RDPC;
            re_pc_reg <= 1'b1;
          end
        end
        S_RDPC: begin
          re_pc_reg <= 1'b0;
          state_reg <= S_LATCH;
        end
        S_LATCH: begin
          cur_pc_reg   <= pc_out;
          imem_req_reg <= 1'b1;
          state_reg    <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack) begin
            imem_req_reg    <= 1'b0;
            instr_reg       <= imem_rdata;
            instr_pc_reg    <= cur_pc_reg;
            instr_valid_reg <= 1'b1;
            state_reg       <= S_ISSUE;
          end else if (fetch_timeout) begin
            imem_req_reg <= 1'b0;
            state_reg    <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (instr_ready) begin
            instr_valid_reg <= 1'b0;
            if (run) begin
              state_reg <= S_RDPC;
              re_pc_reg <= 1'b1;
            end else begin
              state_reg <= S_IDLE;
            end
          end
        end
        default: begin
          state_reg       <= S_IDLE;
          re_pc_reg       <= 1'b0;
          imem_req_reg    <= 1'b0;
          instr_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign re_pc       = re_pc_reg;
  assign wr_pc       = handshake;
  assign pc_in       = handshake ? next_pc : 18'd0;
  assign imem_req    = imem_req_reg;
  assign imem_addr   = cur_pc_reg;
  assign instr_valid = instr_valid_reg;
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign busy        = (state_reg != S_IDLE);

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench for pc_seq_ctrl: driver pushes expected instructions, a monitor checks fetch and issue.
module tb_pc_seq_ctrl;
  localparam int DW      = 32;
  localparam int TIMEOUT = 4;

  logic          clk = 1'b0;
  logic          rst, run, re_pc, wr_pc;
  logic [17:0]   pc_in, pc_out, redirect_addr, imem_addr, instr_pc;
  logic          redirect_valid, imem_req, imem_ack, instr_valid, instr_ready, busy, fetch_err;
  logic [DW-1:0] imem_rdata, instr;

  always #5 clk = ~clk;

  pc_seq_ctrl #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .run(run), .re_pc(re_pc), .wr_pc(wr_pc), .pc_in(pc_in),
    .pc_out(pc_out), .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .busy(busy), .fetch_err(fetch_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] word_of(input logic [17:0] a);
    return {a[13:0] ^ 14'h2A5A, a};
  endfunction

  // PC register and instruction memory models
  logic [17:0] pc_reg;
  logic        load_en;
  logic [17:0] load_val;
  always @(posedge clk) begin
    if (load_en) pc_reg <= load_val;
    else if (wr_pc) pc_reg <= pc_in;
    if (re_pc) pc_out <= pc_reg;
  end
  assign imem_rdata = imem_ack ? word_of(imem_addr) : 32'h0;

  typedef struct {
    logic [17:0] pc;
    logic [17:0] nxt;
    int          period;
  } exp_t;
  exp_t sb[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int last_hs   = 0;
  int proto_err = 0;

  // Monitor: samples 2 time units after the driver's negedge updates
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (re_pc && wr_pc) proto_err++;
        if (wr_pc && !(instr_valid && instr_ready)) proto_err++;
        if (imem_req) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL fetch_addr: fetch of %0h with no expected instruction", imem_addr);
          end else check("fetch_addr", imem_addr, sb[0].pc);
        end
        if (instr_valid) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL issue: instr_pc %0h offered with no expected instruction", instr_pc);
          end else begin
            check("instr_pc", instr_pc, sb[0].pc);
            check("instr", instr, word_of(sb[0].pc));
            if (instr_ready) begin
              check("wr_pc", wr_pc, 1);
              check("pc_in", pc_in, sb[0].nxt);
              if (sb[0].period > 0) check("period", cyc - last_hs, sb[0].period);
              $display("issue pc=%05h next=%05h cycle=%0d", instr_pc, pc_in, cyc);
              last_hs = cyc;
              void'(sb.pop_front());
            end
          end
        end
      end
    end
  end

  // Reference model state: address of the next instruction and an idle-time redirect
  logic [17:0] exp_pc;
  logic        mpend;
  logic [17:0] mpend_addr;

  task automatic do_instr(input int ad, input int rd, input logic [2:0] mode, input int per,
                          input logic last, input logic [17:0] a0, input logic [17:0] a1,
                          input logic [17:0] a2);
    logic [17:0] nxt;
    exp_t        e;
    int          t;
    if (mode[1]) nxt = a1;
    else if (mode[2] && rd > 0) nxt = a2;
    else if (mode[0]) nxt = a0;
    else if (mpend) nxt = mpend_addr;
    else nxt = exp_pc + 18'd1;
    t = 0;
    while (!imem_req && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (!imem_req) begin
      n_checks++;
      $display("FAIL fetch_start: imem_req still 0 after 30 cycles, expected 1");
      return;
    end
    e.pc = exp_pc; e.nxt = nxt; e.period = (per != 0) ? 4 + ad + rd : 0;
    sb.push_back(e);
    exp_pc = nxt;
    mpend  = 1'b0;
    if (mode[0]) begin redirect_valid = 1'b1; redirect_addr = a0; end
    for (int i = 0; i < ad; i++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
    end
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    redirect_valid = 1'b0;
    for (int i = 0; i < rd; i++) begin
      instr_ready = 1'b0;
      if (mode[2] && i == 0) begin redirect_valid = 1'b1; redirect_addr = a2; end
      @(negedge clk);
      redirect_valid = 1'b0;
    end
    instr_ready = 1'b1;
    if (last) run = 1'b0;
    if (mode[1]) begin redirect_valid = 1'b1; redirect_addr = a1; end
    @(negedge clk);
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_re_pc"}, re_pc, 0);
    check({tag, "_wr_pc"}, wr_pc, 0);
    check({tag, "_imem_req"}, imem_req, 0);
    check({tag, "_instr_valid"}, instr_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_fetch_err"}, fetch_err, 0);
  endtask

  task automatic load_pc(input logic [17:0] v);
    load_en = 1'b1; load_val = v;
    @(negedge clk);
    load_en = 1'b0;
    exp_pc = v;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ad, rd;
    logic [2:0] md;
    rst = 1'b1; run = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    imem_ack = 1'b0; instr_ready = 1'b0; load_en = 1'b1; load_val = '0;
    mpend = 1'b0; mpend_addr = '0; exp_pc = '0;
    repeat (3) @(negedge clk);
    load_en = 1'b0;
    check_quiet("reset");
    check("reset_pc_in", pc_in, 0);
    check("reset_imem_addr", imem_addr, 0);
    check("reset_instr_pc", instr_pc, 0);
    check("reset_instr", instr, 0);
    rst = 1'b0;

    // Sequential fetch from 0, zero-wait memory
    run = 1'b1;
    do_instr(0, 0, 3'b000, 0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 4; i++) do_instr(0, 0, 3'b000, 1, 1'b0, '0, '0, '0);
    // Redirect during fetch of PC 5, then two redirects before one issue
    do_instr(0, 0, 3'b001, 1, 1'b0, 18'h00100, '0, '0);
    do_instr(0, 0, 3'b000, 1, 1'b0, '0, '0, '0);
    do_instr(1, 2, 3'b101, 1, 1'b0, 18'h00010, '0, 18'h00020);
    // Slow memory and slow decode: 9-cycle period
    do_instr(3, 2, 3'b000, 1, 1'b0, '0, '0, '0);
    do_instr(3, 2, 3'b000, 1, 1'b0, '0, '0, '0);

    for (int n = 0; n < 30; n++) begin
      ad = $urandom_range(0, 3);
      rd = $urandom_range(0, 3);
      md = 3'($urandom_range(0, 7));
      do_instr(ad, rd, md, 1, 1'b0, 18'($urandom), 18'($urandom), 18'($urandom));
    end
    do_instr(1, 1, 3'b000, 1, 1'b1, '0, '0, '0);
    repeat (3) @(negedge clk);
    check_quiet("stopped");

    // Redirect while idle applies at the end of the next instruction
    redirect_valid = 1'b1; redirect_addr = 18'h02345;
    mpend = 1'b1; mpend_addr = 18'h02345;
    @(negedge clk);
    redirect_valid = 1'b0;
    run = 1'b1;
    do_instr(0, 0, 3'b000, 0, 1'b0, '0, '0, '0);
    do_instr(0, 1, 3'b000, 1, 1'b1, '0, '0, '0);
    repeat (2) @(negedge clk);

    // Wrap of the top address
    load_pc(18'h3FFFF);
    run = 1'b1;
    do_instr(0, 0, 3'b000, 0, 1'b0, '0, '0, '0);
    do_instr(2, 0, 3'b000, 1, 1'b1, '0, '0, '0);
    repeat (2) @(negedge clk);

    // Reset in FETCH with a pending redirect, then a late ack
    load_pc(18'h00007);
    run = 1'b1;
    begin
      exp_t e;
      int t;
      e.pc = exp_pc; e.nxt = '0; e.period = 0;
      sb.push_back(e);
      t = 0;
      while (!imem_req && t < 30) begin @(negedge clk); t++; end
      check("pre_reset_fetch", imem_req, 1);
    end
    redirect_valid = 1'b1; redirect_addr = 18'h03000;
    @(negedge clk);
    redirect_valid = 1'b0; rst = 1'b1; run = 1'b0;
    @(negedge clk);
    sb.delete();
    check_quiet("midreset");
    check("midreset_pc_in", pc_in, 0);
    check("midreset_imem_addr", imem_addr, 0);
    check("midreset_instr", instr, 0);
    rst = 1'b0; imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    check_quiet("late_ack");
    load_pc(18'h00007);
    mpend = 1'b0;
    run = 1'b1;
    do_instr(0, 0, 3'b000, 0, 1'b1, '0, '0, '0);
    repeat (2) @(negedge clk);

`ifdef PCSEQ_FETCH_TIMEOUT_EN
    begin
      exp_t e;
      int t;
      e.pc = exp_pc; e.nxt = '0; e.period = 0;
      sb.push_back(e);
      run = 1'b1;
      t = 0;
      while (!imem_req && t < 30) begin @(negedge clk); t++; end
      t = 0;
      while (imem_req && t < 20) begin @(negedge clk); t++; end
      check("timeout_cycles", t, TIMEOUT);
      check("timeout_err", fetch_err, 1);
      check("timeout_req", imem_req, 0);
      sb.delete();
      repeat (5) @(negedge clk);
      check("timeout_hold_busy", busy, 0);
      check("timeout_hold_err", fetch_err, 1);
      run = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("timeout_cleared", fetch_err, 0);
    end
`endif

    check("sb_drained", sb.size(), 0);
    check("protocol", proto_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Fetch sequencer for the 18-bit program counter register block. It drives the PC read/write strobes and the instruction-memory request handshake, and it computes the next PC: sequential increment or redirect target. It delivers each fetched instruction to decode over a valid/ready handshake. The block sits between the PC register, instruction memory and the decode stage, and is the only writer of the PC.

## Interface
Parameters:
- DW, 32, instruction word width
- TIMEOUT, 255, fetch watchdog limit in cycles (8-bit counter; used only with the macro)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- run  in  1  level; 1 = fetch continuously, 0 = stop at next instruction boundary
- re_pc  out  1  PC read strobe to the PC register
- wr_pc  out  1  PC write strobe to the PC register
- pc_in  out  18  next-PC value to the PC register
- pc_out  in  18  PC register output; valid only the cycle after re_pc
- redirect_valid  in  1  one-cycle request to change the next PC
- redirect_addr  in  18  redirect target
- imem_req  out  1  instruction fetch request
- imem_addr  out  18  fetch address
- imem_ack  in  1  fetch complete; imem_rdata valid in the same cycle
- imem_rdata  in  DW  fetched word
- instr_valid  out  1  instruction offered to decode
- instr_ready  in  1  decode accepts
- instr  out  DW  instruction word
- instr_pc  out  18  address of instr
- busy  out  1  1 in any state other than IDLE
- fetch_err  out  1  sticky watchdog error (macro only; otherwise tied 0)

## Operation
- States: IDLE, RDPC, LATCH, FETCH, ISSUE.
- IDLE: all strobes low. When run=1, go to RDPC.
- RDPC: re_pc=1 for exactly one cycle, then go to LATCH.
- LATCH: capture pc_out into cur_pc, then go to FETCH.
- FETCH: imem_req=1 and imem_addr=cur_pc, held until imem_ack=1. On ack, capture imem_rdata into instr, set instr_pc=cur_pc, go to ISSUE.
- ISSUE: instr_valid=1, held stable until instr_ready=1. In the handshake cycle:
  - wr_pc=1 and pc_in=next_pc.
  - Go to RDPC if run=1, else IDLE.
- next_pc, in priority order:
  - redirect_addr, if redirect_valid=1 this cycle;
  - else the pending redirect target, if one is held;
  - else cur_pc+1, modulo 2^18 (18'h3FFFF wraps to 0).
- Redirect capture:
  - redirect_valid in any non-ISSUE-handshake cycle sets pending and stores the target.
  - If several redirects arrive before consumption, the latest one wins.
  - Pending clears when consumed in the ISSUE handshake.
  - A redirect in IDLE is held and applies at the end of the next instruction.
- re_pc and wr_pc are never high in the same cycle. imem_req is never high outside FETCH.
- Reset, including mid-operation:
  - State goes to IDLE.
  - re_pc, wr_pc, imem_req, instr_valid, busy and fetch_err reset to 0.
  - pc_in, imem_addr, instr_pc and cur_pc reset to 0; instr resets to 0.
  - Pending redirect is cleared.
  - An outstanding fetch is abandoned; any late imem_ack is ignored while in IDLE.

## Timing
- Edge numbering: run is first sampled high at edge 0.
  - Edge 0: state becomes RDPC, so re_pc is high in the cycle after edge 0.
  - LATCH follows one cycle later, then FETCH.
- Zero-wait memory (imem_ack=1 in the first FETCH cycle) with instr_ready held at 1: one instruction every 4 cycles (RDPC, LATCH, FETCH, ISSUE).
- Each cycle of imem_ack low adds 1 cycle. Each cycle of instr_ready low adds 1 cycle.
- Output is registered: instr and instr_pc stay stable for as long as instr_valid=1.
- run=0 mid-instruction: the current instruction completes, including its wr_pc, then the block enters IDLE.

## Configuration
- Macro PCSEQ_FETCH_TIMEOUT_EN defined:
  - An 8-bit counter runs in FETCH and clears on entry to FETCH.
  - If it reaches TIMEOUT with no imem_ack: imem_req drops, fetch_err sets (sticky until rst), and the state goes to IDLE with no wr_pc.
  - While fetch_err=1, IDLE ignores run.
- Macro undefined: FETCH waits indefinitely, no counter logic exists, and fetch_err is constant 0.

## Test plan
- Reset then run=1, pc_out model starting at 0, zero-wait imem, instr_ready=1 -> instr_pc sequence 0,1,2,3. instr_valid pulses every 4th cycle. wr_pc writes 1,2,3,4.
- redirect_valid with addr 18'h00100, pulsed during FETCH of PC 5 -> instr for 5 is issued, pc_in=18'h00100, next instr_pc=18'h00100. Two redirects (0x10 then 0x20) before one ISSUE -> pc_in=0x20.
- Start PC 18'h3FFFF -> pc_in=0 on the ISSUE handshake.
- imem_ack delayed 3 cycles and instr_ready low 2 cycles -> 9-cycle instruction period. imem_addr and instr stable throughout. re_pc and wr_pc never overlap.
- rst asserted in FETCH -> next cycle: IDLE, all outputs 0, busy=0. A late imem_ack is ignored. Pending redirect is cleared.
- With PCSEQ_FETCH_TIMEOUT_EN and TIMEOUT=4, imem_ack never asserted -> fetch_err=1 after 4 FETCH cycles, imem_req=0, no wr_pc, IDLE held despite run=1 until rst.
